timekeeper_ctrl: RTL

//  - Sequences the 1 ms timebase pulse into a 24 h wall clock (hh:mm:ss) and owns the alarm.
//  - Runs the user set-mode FSM driven by two debounced buttons.
//  - Sits between the ms tick generator and the display/alarm-output logic.

---
 rtl/timekeeper_pkg.sv | 29 ++
 rtl/timekeeper_ctrl_if.sv | 28 ++
 rtl/timekeeper_ctrl_edge_pulse.sv | 19 +
 rtl/timekeeper_ctrl.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/timekeeper_pkg.sv
// Shared types and limits for the wall-clock timekeeper.
// Mode encoding doubles as the value driven on the mode output.
package timekeeper_pkg;

    localparam int HR_W    = 5;
    localparam int MIN_W   = 6;
    localparam int SEC_W   = 6;
    localparam int HR_MAX  = 23;
    localparam int MIN_MAX = 59;

    typedef enum logic [2:0] {
        RUN     = 3'd0,
        SET_HR  = 3'd1,
        SET_MIN = 3'd2,
        SET_AH  = 3'd3,
        SET_AM  = 3'd4
    } mode_e;

    function automatic mode_e next_mode(mode_e m);
        unique case (m)
            RUN:     return SET_HR;
            SET_HR:  return SET_MIN;
            SET_MIN: return SET_AH;
            SET_AH:  return SET_AM;
            default: return RUN;
        endcase
    endfunction

endpackage

// File: rtl/timekeeper_ctrl_if.sv
// Tick/button inputs and time/alarm outputs of the timekeeper.
// master drives the inputs, slave is the timekeeper itself.
interface timekeeper_ctrl_if;
    import timekeeper_pkg::*;

    logic             ms_tick;
    logic             btn_mode;
    logic             btn_inc;
    logic             alarm_en;
    logic [HR_W-1:0]  hours;
    logic [MIN_W-1:0] minutes;
    logic [SEC_W-1:0] seconds;
    logic [HR_W-1:0]  alarm_h;
    logic [MIN_W-1:0] alarm_m;
    logic [2:0]       mode;
    logic             ring;

    modport master (
        output ms_tick, btn_mode, btn_inc, alarm_en,
        input  hours, minutes, seconds, alarm_h, alarm_m, mode, ring
    );

    modport slave (
        input  ms_tick, btn_mode, btn_inc, alarm_en,
        output hours, minutes, seconds, alarm_h, alarm_m, mode, ring
    );

endinterface

// File: rtl/timekeeper_ctrl_edge_pulse.sv
// Rising-edge detector: one-cycle pulse on a 0->1 transition.
// A held level produces a single pulse only.
module edge_pulse (
    input  logic clk,
    input  logic reset,
    input  logic lvl_i,
    output logic pulse_o
);

    logic lvl_q;

    always_ff @(posedge clk) begin
        if (reset) lvl_q <= 1'b0;
        else       lvl_q <= lvl_i;
    end

    assign pulse_o = lvl_i & ~lvl_q;

endmodule

// File: rtl/timekeeper_ctrl.sv
// 24 h wall clock, set-mode FSM and alarm driven by a 1 ms tick.
// Optional snooze built when TIMEKEEPER_SNOOZE_EN is defined.
module timekeeper_ctrl
    import timekeeper_pkg::*;
#(
    parameter int MS_PER_SEC  = 1000,
    parameter int ALARM_RST_H = 7,
    parameter int ALARM_RST_M = 0,
    parameter int SNOOZE_MIN  = 5
) (
    input logic              clk,
    input logic              reset,
    timekeeper_ctrl_if.slave bus
);

    localparam int MS_W = (MS_PER_SEC > 1) ? $clog2(MS_PER_SEC) : 1;

    if (SNOOZE_MIN < 1 || SNOOZE_MIN > MIN_MAX) begin : g_bad_snooze
        $error("SNOOZE_MIN out of range");
    end

    mode_e            mode_q;
    logic [MS_W-1:0]  ms_q;
    logic [HR_W-1:0]  hr_q, ah_q, nxt_h;
    logic [MIN_W-1:0] min_q, am_q, nxt_m;
    logic [SEC_W-1:0] sec_q, nxt_s;
    logic             ring_q;

    logic mode_p, inc_raw, inc_p;
    logic frozen, in_run, ms_wrap, sec_tick;
    logic sec_wrap, min_wrap, hr_wrap, am_wrap, ah_wrap;
    logic alarm_hit, snz_hit, dismiss, min_chg;

    edge_pulse u_mode_edge (
        .clk     (clk),
        .reset   (reset),
        .lvl_i   (bus.btn_mode),
        .pulse_o (mode_p)
    );

    edge_pulse u_inc_edge (
        .clk     (clk),
        .reset   (reset),
        .lvl_i   (bus.btn_inc),
        .pulse_o (inc_raw)
    );

    always_comb begin
        inc_p    = inc_raw & ~mode_p;
        frozen   = (mode_q == SET_HR) || (mode_q == SET_MIN);
        in_run   = (mode_q == RUN);
        ms_wrap  = (ms_q == MS_W'(MS_PER_SEC - 1));
        sec_tick = bus.ms_tick && ms_wrap && !frozen;
        sec_wrap = (sec_q == SEC_W'(MIN_MAX));
        min_wrap = (min_q == MIN_W'(MIN_MAX));
        hr_wrap  = (hr_q == HR_W'(HR_MAX));
        am_wrap  = (am_q == MIN_W'(MIN_MAX));
        ah_wrap  = (ah_q == HR_W'(HR_MAX));
        nxt_s    = sec_wrap ? '0 : sec_q + 1'b1;
        nxt_m    = min_q;
        nxt_h    = hr_q;
        if (sec_wrap) begin
            nxt_m = min_wrap ? '0 : min_q + 1'b1;
            if (min_wrap) nxt_h = hr_wrap ? '0 : hr_q + 1'b1;
        end
        // sec_wrap on a tick means the new seconds value is 00
        alarm_hit = in_run && bus.alarm_en && sec_tick && sec_wrap &&
                    (nxt_h == ah_q) && (nxt_m == am_q);
        dismiss   = in_run && inc_p && ring_q;
        min_chg   = sec_tick && sec_wrap;
    end

`ifdef TIMEKEEPER_SNOOZE_EN
    logic             snz_arm_q;
    logic [HR_W-1:0]  snz_h_q, snz_h_d;
    logic [MIN_W-1:0] snz_m_q, snz_m_d;
    logic [MIN_W:0]   snz_sum;

    always_comb begin
        snz_sum = {1'b0, min_q} + (MIN_W+1)'(SNOOZE_MIN);
        snz_m_d = snz_sum[MIN_W-1:0];
        snz_h_d = hr_q;
        if (snz_sum > (MIN_W+1)'(MIN_MAX)) begin
            snz_m_d = MIN_W'(snz_sum - (MIN_W+1)'(MIN_MAX + 1));
            snz_h_d = hr_wrap ? '0 : hr_q + 1'b1;
        end
        snz_hit = snz_arm_q && in_run && bus.alarm_en && sec_tick &&
                  sec_wrap && (nxt_h == snz_h_q) && (nxt_m == snz_m_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            snz_arm_q <= 1'b0;
            snz_h_q   <= '0;
            snz_m_q   <= '0;
        end else begin
            if (snz_hit) snz_arm_q <= 1'b0;
            if (dismiss) begin
                snz_arm_q <= 1'b1;
                snz_h_q   <= snz_h_d;
                snz_m_q   <= snz_m_d;
            end
            if (!bus.alarm_en || !in_run) snz_arm_q <= 1'b0;
        end
    end
`else
    assign snz_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q <= RUN;
            ms_q   <= '0;
            hr_q   <= '0;
            min_q  <= '0;
            sec_q  <= '0;
            ah_q   <= HR_W'(ALARM_RST_H);
            am_q   <= MIN_W'(ALARM_RST_M);
            ring_q <= 1'b0;
        end else begin
            if (mode_p) mode_q <= next_mode(mode_q);
            if (!frozen && bus.ms_tick) ms_q <= ms_wrap ? '0 : ms_q + 1'b1;
            if (sec_tick) begin
                sec_q <= nxt_s;
                min_q <= nxt_m;
                hr_q  <= nxt_h;
            end
            if (inc_p) begin
                unique case (1'b1)
                    (mode_q == SET_HR):  hr_q  <= hr_wrap ? '0 : hr_q + 1'b1;
                    (mode_q == SET_MIN): min_q <= min_wrap ? '0 : min_q + 1'b1;
                    (mode_q == SET_AH):  ah_q  <= ah_wrap ? '0 : ah_q + 1'b1;
                    (mode_q == SET_AM):  am_q  <= am_wrap ? '0 : am_q + 1'b1;
                    default: ;
                endcase
            end
            // committing a new time restarts the second from its start
            if (mode_p && mode_q == SET_MIN) begin
                sec_q <= '0;
                ms_q  <= '0;
            end
            if (dismiss || min_chg) ring_q <= 1'b0;
            if (alarm_hit || snz_hit) ring_q <= 1'b1;
            if (!bus.alarm_en || (mode_p && in_run)) ring_q <= 1'b0;
        end
    end

    assign bus.hours   = hr_q;
    assign bus.minutes = min_q;
    assign bus.seconds = sec_q;
    assign bus.alarm_h = ah_q;
    assign bus.alarm_m = am_q;
    assign bus.mode    = mode_q;
    assign bus.ring    = ring_q;

endmodule
